mixed_acc_sequencer: RTL and testbench

// - Sequences the shared 32-bit mixed-precision adder (adder_32_bits) through multi-operand accumulations.
// - Two modes: full 32-bit wrap-around sum, or packed dual-lane sum (2 x 10-bit signed, saturated).
// - Sits between operand producers (MAC / load path) and the writeback of the mixed-precision extension.
// - Streams LEN operands in, then presents one result.

---
 rtl/mixed_acc_pkg.sv | 36 +++
 rtl/adder_32_bits.sv | 43 ++++
 rtl/mixed_acc_sequencer.sv | 161 ++++++++++++++++
 tb/tb_mixed_acc_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mixed_acc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mixed_acc_pkg
//  Brief    : Shared types and constants for the mixed-precision accumulation
//             sequencer: FSM states and packed dual-lane field geometry.
//  Revision : 1.0 - initial release
// ============================================================================
package mixed_acc_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Packed lane geometry: 10-bit signed lanes, 12-bit signed lane sums
    localparam int LANE_W     = 10;
    localparam int LANE_SUM_W = 12;
    localparam int LANE_MAX   = 511;
    localparam int LANE_MIN   = -512;

    // Lane positions in operands/results and in the adder's packed sum
    localparam int LANE0_LSB  = 0;
    localparam int LANE1_LSB  = 12;
    localparam int SUM0_LSB   = 0;
    localparam int SUM1_LSB   = 16;

    // Result of clamping/truncating one lane sum back to lane width
    typedef struct packed {
        logic [LANE_W-1:0] val;
        logic              clamped;
    } lane_res_t;

endpackage
`default_nettype wire

// File: rtl/adder_32_bits.sv
`default_nettype none
// ============================================================================
//  Module   : adder_32_bits
//  Brief    : Shared mixed-precision adder. mode_3=0: 32-bit wrap-around sum.
//             mode_3=1: two 10-bit signed lanes summed into 12-bit signed
//             results at [27:16] (lane1) and [11:0] (lane0); other bits 0.
//  Revision : 1.0 - initial release
// ============================================================================
module adder_32_bits
    import mixed_acc_pkg::*;
(
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        mode_3,
    output logic [31:0] out_res
);

    localparam int c_EXT_W = LANE_SUM_W - LANE_W;

    logic [LANE_SUM_W-1:0] w_sum0;
    logic [LANE_SUM_W-1:0] w_sum1;

    // Sign-extend each lane to the sum width so the lane sums cannot overflow
    always_comb begin
        w_sum0 = {{c_EXT_W{operand_a[LANE0_LSB+LANE_W-1]}}, operand_a[LANE0_LSB +: LANE_W]}
               + {{c_EXT_W{operand_b[LANE0_LSB+LANE_W-1]}}, operand_b[LANE0_LSB +: LANE_W]};
        w_sum1 = {{c_EXT_W{operand_a[LANE1_LSB+LANE_W-1]}}, operand_a[LANE1_LSB +: LANE_W]}
               + {{c_EXT_W{operand_b[LANE1_LSB+LANE_W-1]}}, operand_b[LANE1_LSB +: LANE_W]};
    end

    // Select full-width sum or the packed lane sums
    always_comb begin
        out_res = '0;
        if (mode_3) begin
            out_res[SUM0_LSB +: LANE_SUM_W] = w_sum0;
            out_res[SUM1_LSB +: LANE_SUM_W] = w_sum1;
        end else begin
            out_res = operand_a + operand_b;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mixed_acc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mixed_acc_sequencer
//  Brief    : Streams LEN operands through the shared adder and presents one
//             accumulated result: full 32-bit wrap sum or packed dual-lane
//             10-bit signed sum (saturating or wrapping per SAT_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module mixed_acc_sequencer
    import mixed_acc_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter bit SAT_EN = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic             mode_i,
    input  logic             abort_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      out_data_o,
    output logic             out_sat_o,
    output logic             busy_o
);

    localparam logic signed [LANE_SUM_W-1:0] c_LANE_MAX = LANE_SUM_W'(LANE_MAX);
    localparam logic signed [LANE_SUM_W-1:0] c_LANE_MIN = LANE_SUM_W'(LANE_MIN);

    state_t             r_state;
    state_t             w_next_state;
    logic [31:0]        r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sat;
    logic               r_mode;

    logic [31:0]        w_add_res;
    logic [31:0]        w_acc_next;
    logic               w_sat_hit;
    logic               w_hs;
    logic               w_last;
    lane_res_t          w_lane0;
    lane_res_t          w_lane1;

    // Bring a 12-bit lane sum back to 10 bits: clamp (SAT_EN) or truncate
    function automatic lane_res_t clamp_lane(input logic [LANE_SUM_W-1:0] sum);
        lane_res_t res;
        res.val     = sum[LANE_W-1:0];
        res.clamped = 1'b0;
        if (SAT_EN) begin
            if ($signed(sum) > c_LANE_MAX) begin
                res.val     = c_LANE_MAX[LANE_W-1:0];
                res.clamped = 1'b1;
            end else if ($signed(sum) < c_LANE_MIN) begin
                res.val     = c_LANE_MIN[LANE_W-1:0];
                res.clamped = 1'b1;
            end
        end
        return res;
    endfunction

    // Single shared adder: accumulator plus incoming operand
    adder_32_bits u_adder (
        .operand_a (r_acc),
        .operand_b (in_data_i),
        .mode_3    (r_mode),
        .out_res   (w_add_res)
    );

    assign w_hs   = in_valid_i && (r_state == ACCUM);
    assign w_last = w_hs && (r_cnt == CNT_W'(1));

    // Next accumulator value: raw sum in full mode, clamped/repacked lanes otherwise
    always_comb begin
        w_lane0    = clamp_lane(w_add_res[SUM0_LSB +: LANE_SUM_W]);
        w_lane1    = clamp_lane(w_add_res[SUM1_LSB +: LANE_SUM_W]);
        w_acc_next = w_add_res;
        w_sat_hit  = 1'b0;
        if (r_mode) begin
            w_acc_next                        = '0;
            w_acc_next[LANE0_LSB +: LANE_W]   = w_lane0.val;
            w_acc_next[LANE1_LSB +: LANE_W]   = w_lane1.val;
            w_sat_hit                         = w_lane0.clamped || w_lane1.clamped;
        end
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs; abort overrides every transition
    always_comb begin
        w_next_state = r_state;
        in_ready_o   = 1'b0;
        out_valid_o  = 1'b0;
        busy_o       = (r_state != IDLE);
        out_data_o   = '0;
        out_sat_o    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_next_state = (len_i == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                in_ready_o = 1'b1;
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                out_valid_o = 1'b1;
                out_data_o  = r_acc;
                out_sat_o   = r_sat;
                if (out_ready_i) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
        if (abort_i) begin
            w_next_state = IDLE;
        end
    end

    // Job datapath: load on start, accumulate on each accepted operand
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_sat  <= 1'b0;
            r_mode <= 1'b0;
        end else if (abort_i) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_sat  <= 1'b0;
        end else if ((r_state == IDLE) && start_i) begin
            r_acc  <= '0;
            r_sat  <= 1'b0;
            r_cnt  <= len_i;
            r_mode <= mode_i;
        end else if (w_hs) begin
            r_acc  <= w_acc_next;
            r_cnt  <= r_cnt - CNT_W'(1);
            r_sat  <= r_sat || w_sat_hit;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mixed_acc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mixed_acc_sequencer
//  Brief    : Self-checking bench: directed scenarios plus randomized jobs,
//             results predicted by a lane-arithmetic model and checked by a
//             scoreboard monitor decoupled from the stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mixed_acc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        mode;
    logic        abort;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_sat;
    logic        busy;

    typedef struct {
        logic [31:0] d;
        logic        s;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] job_ops[256];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          hold_cnt = 0;
    int          held_cycles = 0;
    bit          prev_held = 1'b0;
    logic [31:0] prev_d = '0;
    logic        prev_s = 1'b0;

    always #5 clk = ~clk;

    mixed_acc_sequencer dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .len_i       (len),
        .mode_i      (mode),
        .abort_i     (abort),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_sat_o   (out_sat),
        .busy_o      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, req);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Reference: each lane is an integer that is clamped after every add
    function automatic exp_t model(input bit m, input int l);
        exp_t              r;
        logic [31:0]       acc = '0;
        int                lanes[2];
        logic signed [9:0] x;
        r.s = 1'b0;
        lanes[0] = 0;
        lanes[1] = 0;
        for (int i = 0; i < l; i++) begin
            if (!m) begin
                acc = acc + job_ops[i];
            end else begin
                for (int k = 0; k < 2; k++) begin
                    x = (k == 0) ? job_ops[i][9:0] : job_ops[i][21:12];
                    lanes[k] = lanes[k] + int'(x);
                    if (lanes[k] > 511) begin lanes[k] = 511; r.s = 1'b1; end
                    if (lanes[k] < -512) begin lanes[k] = -512; r.s = 1'b1; end
                end
            end
        end
        if (m) acc = {10'd0, 10'(lanes[1]), 2'd0, 10'(lanes[0])};
        r.d = acc;
        return r;
    endfunction

    // Scoreboard monitor; also owns out_ready (random, or forced low for hold tests)
    always @(negedge clk) begin
        if (out_valid && prev_held) begin
            check("hold_data", out_data, prev_d);
            check("hold_sat", {31'd0, out_sat}, {31'd0, prev_s});
        end
        if (out_valid && held_cycles < hold_cnt) begin
            out_ready = 1'b0;
            held_cycles++;
        end else begin
            out_ready = ($urandom_range(0, 3) != 0);
        end
        if (!out_valid) held_cycles = 0;
        if (out_valid && out_ready && !rst) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_result: actual 0x%08h required none", out_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result_data", out_data, e.d);
                check("result_sat", {31'd0, out_sat}, {31'd0, e.s});
            end
            prev_held   = 1'b0;
            held_cycles = 0;
        end else begin
            prev_held = out_valid;
            prev_d    = out_data;
            prev_s    = out_sat;
        end
    end

    task automatic do_start(input bit m, input logic [7:0] l);
        int t = 0;
        while (busy && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) fail_now("start_wait_idle");
        start = 1'b1;
        mode  = m;
        len   = l;
        @(negedge clk);
        start = 1'b0;
        mode  = 1'($urandom);
        len   = 8'($urandom);
    endtask

    task automatic send(input logic [31:0] d);
        bit r;
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 200; t++) begin
            r = in_ready;
            @(negedge clk);
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        in_data  = $urandom;
        if (!ok) fail_now("operand_accept");
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) fail_now("result_drain");
    endtask

    // gap_mode: 0 back-to-back, 1 random bubbles, 2 bubble between every operand
    task automatic run_job(input bit m, input int l, input int gap_mode, input bit start_mid,
                           input bit use_ovr, input logic [31:0] od, input bit os);
        exp_t e;
        if (use_ovr) begin
            e.d = od;
            e.s = os;
        end else begin
            e = model(m, l);
        end
        exp_q.push_back(e);
        do_start(m, 8'(l));
        if (l == 0) check("len0_valid_latency", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < l; i++) begin
            if (i > 0 && (gap_mode == 2 || (gap_mode == 1 && $urandom_range(0, 1) == 1)))
                @(negedge clk);
            if (start_mid && i == 1) begin
                start = 1'b1;
                len   = 8'd99;
                mode  = ~m;
            end
            send(job_ops[i]);
            start = 1'b0;
        end
        if (l > 0) check("done_valid_latency", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_data"}, out_data, 32'd0);
        check({tag, "_flags"}, {28'd0, out_valid, in_ready, out_sat, busy}, 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        len      = '0;
        mode     = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");

        // Full mode wrap-around
        job_ops[0] = 32'h7FFF_FFFF; job_ops[1] = 32'd1; job_ops[2] = 32'd5;
        run_job(1'b0, 3, 0, 1'b0, 1'b1, 32'h8000_0005, 1'b0);
        drain();

        // Packed saturation: lane0 300+300 -> 511, lane1 -5 + -7 -> -12
        job_ops[0] = (32'h3FB << 12) | 32'd300;
        job_ops[1] = (32'h3F9 << 12) | 32'd300;
        run_job(1'b1, 2, 0, 1'b0, 1'b1, 32'h003F_41FF, 1'b1);
        drain();

        // Packed with bubbles and a 3-cycle back-pressured result
        for (int i = 0; i < 4; i++) job_ops[i] = $urandom;
        hold_cnt = 3;
        run_job(1'b1, 4, 2, 1'b0, 1'b0, '0, 1'b0);
        drain();
        hold_cnt = 0;

        // Zero-length job
        run_job(1'b1, 0, 0, 1'b0, 1'b1, 32'd0, 1'b0);
        drain();

        // start while accumulating must not reload the count or mode
        for (int i = 0; i < 3; i++) job_ops[i] = $urandom;
        run_job(1'b0, 3, 0, 1'b1, 1'b0, '0, 1'b0);
        drain();

        // Abort after 2 of 5 operands, then a fresh job
        do_start(1'b0, 8'd5);
        send(32'h1234_5678);
        send(32'h0FFF_0001);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_flags", {29'd0, busy, in_ready, out_valid}, 32'd0);
        job_ops[0] = 32'd7;
        run_job(1'b0, 1, 0, 1'b0, 1'b1, 32'd7, 1'b0);
        drain();

        // Asynchronous reset in the middle of accumulation
        do_start(1'b1, 8'd4);
        send(32'h0000_0100);
        #2 rst = 1'b1;
        #1 check_all_zero("rst_mid_accum");
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset while a saturated result is held
        hold_cnt = 1000;
        @(negedge clk);
        do_start(1'b1, 8'd2);
        send(32'd300);
        send(32'd300);
        check("pre_rst_done_valid", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("rst_mid_done");
        @(negedge clk);
        hold_cnt = 0;
        rst = 1'b0;
        @(negedge clk);

        // Randomized jobs
        for (int j = 0; j < 30; j++) begin
            int l;
            bit m;
            l = $urandom_range(0, 10);
            m = 1'($urandom);
            for (int i = 0; i < l; i++) job_ops[i] = $urandom;
            run_job(m, l, 1, 1'b0, 1'b0, '0, 1'b0);
        end
        drain();
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
